ics2_lookup: RTL and testbench

- Second instruction-cache stage; sits directly downstream of the stage-1 restart block.
- Consumes the stage-1 read address and valid. Performs a direct-mapped tag/data lookup and returns the instruction on a hit.
- On a miss: drives the miss indication and the missed address back to stage 1, fetches the line from memory over a valid/ready interface, fills the arrays, then releases the miss so stage 1 replays the address.

---
 rtl/ics2_lookup_pkg.sv | 26 ++
 rtl/ics2_lookup_if.sv | 25 ++
 rtl/ics2_line_store.sv | 62 ++++++
 rtl/ics2_lookup.sv | 161 ++++++++++++++++
 tb/tb_ics2_lookup.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ics2_lookup_pkg.sv
// Shared types and address-split helpers for the instruction-cache stage-2 lookup.
// No logic: defaults, FSM encoding and offset/index/tag width functions.
package ics_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_REFILL = 2'd2
  } ics2_state_e;

  function automatic int off_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int addr_width, input int num_lines, input int words_per_line);
    return addr_width - $clog2(num_lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/ics2_lookup_if.sv
// Line-refill memory bus: one request beat (line base), then WORDS_PER_LINE data beats.
// Both directions valid/ready; master is the cache, slave is the memory.
interface ics2_lookup_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) ();

  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_data_valid;
  logic                  mem_data_ready;

  modport master (
    output mem_req_addr, mem_req_valid, mem_data_ready,
    input  mem_req_ready, mem_data, mem_data_valid
  );

  modport slave (
    input  mem_req_addr, mem_req_valid, mem_data_ready,
    output mem_req_ready, mem_data, mem_data_valid
  );

endinterface

// File: rtl/ics2_line_store.sv
// Direct-mapped valid/tag/data arrays: one word write port, tag+valid set on fill, clear-all.
// Reads are combinational; writes land on the next clock edge; clear-all beats a same-cycle set.
module ics2_line_store
  import ics_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 10,
  localparam int OB            = off_bits(WORDS_PER_LINE),
  localparam int IB            = idx_bits(NUM_LINES)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  clr_all,
  input  logic                  wr_en,
  input  logic [IB-1:0]         wr_index,
  input  logic [OB-1:0]         wr_offset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  fill_done,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [IB-1:0]         rd_index,
  input  logic [OB-1:0]         rd_offset,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [TAG_W-1:0]      tag_d  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES][WORDS_PER_LINE];
  logic [DATA_WIDTH-1:0] data_d [NUM_LINES][WORDS_PER_LINE];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) data_d[wr_index][wr_offset] = wr_data;
    if (fill_done) begin
      tag_d[wr_index]   = fill_tag;
      valid_d[wr_index] = 1'b1;
    end
    if (clr_all) valid_d = '0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  // Tag/data need no reset: nothing reads them until the line's valid bit is set.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/ics2_lookup.sv
// I-cache stage 2: direct-mapped lookup, 1-cycle hit latency; misses stall stage 1 until a line refill completes.
// i_halt freezes everything; refill beats accepted only in REFILL & ~i_halt. Optional ICS2_PERF_CNT_EN adds hit/miss counters.
module ics2_lookup
  import ics_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_halt,
  input  logic [ADDR_WIDTH-1:0] i_r_addr,
  input  logic                  i_r_addr_valid,
  input  logic                  i_invalidate,
  output logic                  o_miss_state,
  output logic [ADDR_WIDTH-1:0] o_prev_r_addr,
  output logic                  o_prev_r_addr_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_instr_addr,
  output logic                  o_instr_valid,
  ics2_lookup_if.master         mem
`ifdef ICS2_PERF_CNT_EN
  ,
  output logic [15:0]           o_hit_count,
  output logic [15:0]           o_miss_count
`endif
);

  localparam int OB = off_bits(WORDS_PER_LINE);
  localparam int IB = idx_bits(NUM_LINES);
  localparam int TB = tag_bits(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d, miss_addr_q, miss_addr_d;
  logic                  vld_q, vld_d, pend_inv_q, pend_inv_d;
  logic [OB-1:0]         beat_q, beat_d;
  ics2_state_e           state_q, state_d;

  logic                  ls_valid;
  logic [TB-1:0]         ls_tag;
  logic [DATA_WIDTH-1:0] ls_data;
  logic                  is_idle, hit, miss_det, beat, last_beat, apply_inv;

  ics2_line_store #(
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_LINES     (NUM_LINES),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .TAG_W         (TB)
  ) u_store (
    .clk      (clk),
    .arst_n   (arst_n),
    .clr_all  (apply_inv),
    .wr_en    (beat),
    .wr_index (miss_addr_q[OB+IB-1:OB]),
    .wr_offset(beat_q),
    .wr_data  (mem.mem_data),
    .fill_done(last_beat),
    .fill_tag (miss_addr_q[ADDR_WIDTH-1:OB+IB]),
    .rd_index (addr_q[OB+IB-1:OB]),
    .rd_offset(addr_q[OB-1:0]),
    .rd_valid (ls_valid),
    .rd_tag   (ls_tag),
    .rd_data  (ls_data)
  );

  assign is_idle   = (state_q == ST_IDLE);
  assign hit       = vld_q & ls_valid & (ls_tag == addr_q[ADDR_WIDTH-1:OB+IB]);
  assign miss_det  = is_idle & vld_q & ~hit;
  assign beat      = (state_q == ST_REFILL) & ~i_halt & mem.mem_data_valid;
  assign last_beat = beat & (beat_q == OB'(WORDS_PER_LINE - 1));
  // Invalidates seen mid-miss or under halt are parked and applied on the first free IDLE cycle.
  assign apply_inv = is_idle & ~i_halt & (i_invalidate | pend_inv_q);

  always_comb begin
    addr_d      = addr_q;
    vld_d       = vld_q;
    miss_addr_d = miss_addr_q;
    beat_d      = beat_q;
    state_d     = state_q;
    pend_inv_d  = pend_inv_q;
    if (!i_halt) begin
      case (state_q)
        ST_IDLE: begin
          addr_d = i_r_addr;
          vld_d  = i_r_addr_valid;
          if (miss_det) begin
            vld_d       = 1'b0;
            miss_addr_d = addr_q;
            state_d     = ST_REQ;
          end
        end
        ST_REQ: if (mem.mem_req_ready) state_d = ST_REFILL;
        ST_REFILL: begin
          if (beat) beat_d = beat_q + OB'(1);
          if (last_beat) begin
            beat_d  = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (apply_inv)         pend_inv_d = 1'b0;
    else if (i_invalidate) pend_inv_d = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr_q      <= '0;
      vld_q       <= 1'b0;
      miss_addr_q <= '0;
      beat_q      <= '0;
      state_q     <= ST_IDLE;
      pend_inv_q  <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      vld_q       <= vld_d;
      miss_addr_q <= miss_addr_d;
      beat_q      <= beat_d;
      state_q     <= state_d;
      pend_inv_q  <= pend_inv_d;
    end
  end

  assign o_miss_state        = miss_det | ~is_idle;
  assign o_prev_r_addr_valid = o_miss_state;
  assign o_prev_r_addr       = miss_det ? addr_q : (is_idle ? '0 : miss_addr_q);
  assign o_instr_valid       = is_idle & hit & ~i_halt;
  assign o_instr             = o_instr_valid ? ls_data : '0;
  assign o_instr_addr        = o_instr_valid ? addr_q : '0;

  assign mem.mem_req_valid  = (state_q == ST_REQ);
  assign mem.mem_req_addr   = mem.mem_req_valid ? {miss_addr_q[ADDR_WIDTH-1:OB], {OB{1'b0}}} : '0;
  assign mem.mem_data_ready = (state_q == ST_REFILL) & ~i_halt;

`ifdef ICS2_PERF_CNT_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (o_instr_valid && hit_cnt_q != 16'hFFFF)            hit_cnt_d  = hit_cnt_q + 16'd1;
    if (miss_det && !i_halt && miss_cnt_q != 16'hFFFF)     miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_hit_count  = hit_cnt_q;
  assign o_miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ics2_lookup.sv
// Directed bench for ics2_lookup: expected hits go to a scoreboard queue, a negedge monitor pops and compares.
// Covers cold miss, back-to-back hits, conflict, halt mid-refill, invalidate (mid-refill and idle), reset mid-refill.
module tb_ics2_lookup;
  import ics_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        i_halt = 1'b0;
  logic [15:0] i_r_addr = '0;
  logic        i_r_addr_valid = 1'b0;
  logic        i_invalidate = 1'b0;
  logic        o_miss_state, o_prev_r_addr_valid, o_instr_valid;
  logic [15:0] o_prev_r_addr, o_instr, o_instr_addr;
`ifdef ICS2_PERF_CNT_EN
  logic [15:0] o_hit_count, o_miss_count;
`endif

  ics2_lookup_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) mif ();

  ics2_lookup #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .NUM_LINES(16), .WORDS_PER_LINE(4)
  ) dut (
    .clk                (clk),
    .arst_n             (arst_n),
    .i_halt             (i_halt),
    .i_r_addr           (i_r_addr),
    .i_r_addr_valid     (i_r_addr_valid),
    .i_invalidate       (i_invalidate),
    .o_miss_state       (o_miss_state),
    .o_prev_r_addr      (o_prev_r_addr),
    .o_prev_r_addr_valid(o_prev_r_addr_valid),
    .o_instr            (o_instr),
    .o_instr_addr       (o_instr_addr),
    .o_instr_valid      (o_instr_valid),
    .mem                (mif.master)
`ifdef ICS2_PERF_CNT_EN
    ,
    .o_hit_count        (o_hit_count),
    .o_miss_count       (o_miss_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every hit the DUT presents must match the oldest expected hit, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (arst_n && o_instr_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_hit actual=%h@%h required=none", o_instr, o_instr_addr);
      end else begin
        e = sb.pop_front();
        chk("hit_data", {16'h0, o_instr}, {16'h0, e.data});
        chk("hit_addr", {16'h0, o_instr_addr}, {16'h0, e.addr});
        chk("hit_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic present_hit(input logic [15:0] a, input logic [15:0] d);
    i_r_addr = a;
    i_r_addr_valid = 1'b1;
    sb.push_back('{addr: a, data: d, cyc: cyc + 1});
    @(posedge clk);
    #1;
    i_r_addr_valid = 1'b0;
  endtask

  // Replay in the first IDLE cycle after a fill; the miss must already have dropped.
  task automatic replay_hit(input logic [15:0] a, input logic [15:0] d);
    i_r_addr = a;
    i_r_addr_valid = 1'b1;
    sb.push_back('{addr: a, data: d, cyc: cyc + 1});
    @(negedge clk);
    chk("miss_dropped", {31'h0, o_miss_state}, 32'h0);
    @(posedge clk);
    #1;
    i_r_addr_valid = 1'b0;
  endtask

  task automatic present_miss(input logic [15:0] a);
    i_r_addr = a;
    i_r_addr_valid = 1'b1;
    @(posedge clk);
    #1;
    i_r_addr_valid = 1'b0;
    @(negedge clk);
    chk("miss_state", {31'h0, o_miss_state}, 32'h1);
    chk("prev_addr", {16'h0, o_prev_r_addr}, {16'h0, a});
    chk("prev_addr_vld", {31'h0, o_prev_r_addr_valid}, 32'h1);
  endtask

  task automatic mem_serve(input logic [15:0] exp_addr, input logic [15:0] d0,
                           input int halt_after, input int inv_at, input int rst_after);
    int n;
    n = 0;
    while (!mif.mem_req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mif.mem_req_valid) begin
      total++;
      bad++;
      $display("FAIL req_timeout actual=no_request required=%h", exp_addr);
      return;
    end
    chk("req_addr", {16'h0, mif.mem_req_addr}, {16'h0, exp_addr});
    @(posedge clk);
    #1;
    mif.mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    mif.mem_req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == rst_after) begin
        arst_n = 1'b0;
        mif.mem_data_valid = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {31'h0, |{o_miss_state, o_prev_r_addr, o_prev_r_addr_valid, o_instr,
            o_instr_addr, o_instr_valid, mif.mem_req_addr, mif.mem_req_valid, mif.mem_data_ready}}, 32'h0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("no_reissue", {30'h0, mif.mem_req_valid, o_miss_state}, 32'h0);
        @(posedge clk);
        #1;
        return;
      end
      if (b == halt_after) begin
        i_halt = 1'b1;
        mif.mem_data_valid = 1'b1;
        mif.mem_data = d0 + 16'(b);
        repeat (3) begin
          @(negedge clk);
          chk("halt_data_rdy", {31'h0, mif.mem_data_ready}, 32'h0);
          chk("halt_miss", {31'h0, o_miss_state}, 32'h1);
          @(posedge clk);
          #1;
        end
        i_halt = 1'b0;
      end
      if (b == inv_at) i_invalidate = 1'b1;
      mif.mem_data_valid = 1'b1;
      mif.mem_data = d0 + 16'(b);
      n = 0;
      @(negedge clk);
      while (!mif.mem_data_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!mif.mem_data_ready) begin
        total++;
        bad++;
        $display("FAIL beat_timeout actual=not_ready required=ready beat=%0d", b);
        mif.mem_data_valid = 1'b0;
        i_invalidate = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      i_invalidate = 1'b0;
    end
    mif.mem_data_valid = 1'b0;
  endtask

  initial begin
    mif.mem_req_ready  = 1'b0;
    mif.mem_data       = '0;
    mif.mem_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {31'h0, |{o_miss_state, o_prev_r_addr, o_prev_r_addr_valid, o_instr,
        o_instr_addr, o_instr_valid, mif.mem_req_addr, mif.mem_req_valid, mif.mem_data_ready}}, 32'h0);
    arst_n = 1'b1;
    idle(2);

    // Cold miss at 0x0046, line 0x0044 filled with A000..A003.
    present_miss(16'h0046);
    mem_serve(16'h0044, 16'hA000, -1, -1, -1);
    replay_hit(16'h0046, 16'hA002);
    idle(2);

    // Back-to-back hits on the filled line.
    present_hit(16'h0044, 16'hA000);
    present_hit(16'h0045, 16'hA001);
    present_hit(16'h0047, 16'hA003);
    idle(2);

    // Conflict on index 1, then refetch 0x0044 with a 3-cycle halt after two beats.
    present_miss(16'h0004);
    mem_serve(16'h0004, 16'hB000, -1, -1, -1);
    replay_hit(16'h0004, 16'hB000);
    idle(1);
    present_miss(16'h0044);
    mem_serve(16'h0044, 16'hA000, 2, -1, -1);
    replay_hit(16'h0044, 16'hA000);
    present_hit(16'h0046, 16'hA002);
    present_hit(16'h0047, 16'hA003);
    idle(2);

    // Invalidate during refill of 0x0088: the fresh line and line 0x0044 are both dropped.
    present_miss(16'h0088);
    mem_serve(16'h0088, 16'hC000, -1, 1, -1);
    present_miss(16'h0088);
    mem_serve(16'h0088, 16'hC000, -1, -1, -1);
    replay_hit(16'h0088, 16'hC000);
    present_hit(16'h008B, 16'hC003);
    idle(1);
    present_miss(16'h0046);
    mem_serve(16'h0044, 16'hA000, -1, -1, -1);
    replay_hit(16'h0046, 16'hA002);
    idle(2);

    // Invalidate in IDLE: the same-cycle lookup still hits, the next one misses.
    i_r_addr = 16'h0045;
    i_r_addr_valid = 1'b1;
    sb.push_back('{addr: 16'h0045, data: 16'hA001, cyc: cyc + 1});
    @(posedge clk);
    #1;
    i_r_addr_valid = 1'b0;
    i_invalidate = 1'b1;
    @(posedge clk);
    #1;
    i_invalidate = 1'b0;
    present_miss(16'h0045);

    // Reset after two refill beats: partial line discarded, 0x0046 misses again.
    mem_serve(16'h0044, 16'hA000, -1, -1, 2);
    present_miss(16'h0046);
    mem_serve(16'h0044, 16'hA000, -1, -1, -1);
    replay_hit(16'h0046, 16'hA002);
    idle(3);

    chk("sb_drain", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
